// File: rtl/adc_idelay_calib.sv
// Per-channel IODELAYE1 tap calibration: sweeps every tap on each channel in turn,
// finds the widest passing window and loads its floor centre (or DEFAULT_TAP on failure).
module adc_idelay_calib #(
    parameter int CHANNELS       = 4,
    parameter int CNTVALUE_WIDTH = 5,
    parameter int DEFAULT_TAP    = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int SAMPLE_CYCLES  = 8,
    parameter int MIN_WINDOW     = 3
) (
    input  logic                                 refclk,
    input  logic                                 rst_asyn_n,
    input  logic                                 cal_start,
    input  logic [CHANNELS-1:0]                  pattern_ok,
    output logic [CHANNELS*CNTVALUE_WIDTH-1:0]   dly_cntvalue,
    output logic [CHANNELS-1:0]                  dly_ld,
    output logic                                 cal_busy,
    output logic                                 cal_done,
    output logic [CHANNELS-1:0]                  cal_fail
);

    localparam int W    = CNTVALUE_WIDTH;
    localparam int TAPS = 1 << W;
    localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CMAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNTW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, EVAL, CENTER, NEXT_CH, DONE} state_t;

    state_t              state_reg, state_next;
    logic [CHW-1:0]      ch_reg, ch_next, ch_inc;
    logic [W-1:0]        tap_reg, tap_next;
    logic [CNTW-1:0]     cnt_reg, cnt_next;
    logic                pass_reg, pass_next;
    logic                start_reg, start_next;
    logic [W:0]          run_len_reg, run_len_next, best_len_reg, best_len_next;
    logic [W-1:0]        run_start_reg, run_start_next, best_start_reg, best_start_next;
    logic [W-1:0]        lane_reg [CHANNELS];
    logic [W-1:0]        lane_next [CHANNELS];
    logic [CHANNELS-1:0] ld_reg, ld_next, fail_reg, fail_next;
    logic                busy_reg, busy_next, done_reg, done_next;
    logic [W:0]          rl, bl, centre;
    logic [W-1:0]        rs, bs;

    always_ff @(posedge refclk or negedge rst_asyn_n) begin
        if (!rst_asyn_n) begin
            state_reg      <= IDLE;
            ch_reg         <= '0;
            tap_reg        <= '0;
            cnt_reg        <= '0;
            pass_reg       <= 1'b0;
            start_reg      <= 1'b0;
            run_len_reg    <= '0;
            run_start_reg  <= '0;
            best_len_reg   <= '0;
            best_start_reg <= '0;
            for (int i = 0; i < CHANNELS; i++) lane_reg[i] <= W'(DEFAULT_TAP);
            ld_reg         <= '0;
            fail_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ch_reg         <= ch_next;
            tap_reg        <= tap_next;
            cnt_reg        <= cnt_next;
            pass_reg       <= pass_next;
            start_reg      <= start_next;
            run_len_reg    <= run_len_next;
            run_start_reg  <= run_start_next;
            best_len_reg   <= best_len_next;
            best_start_reg <= best_start_next;
            for (int i = 0; i < CHANNELS; i++) lane_reg[i] <= lane_next[i];
            ld_reg         <= ld_next;
            fail_reg       <= fail_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    // Outputs are registered, so lane/strobe values are computed on the transition into LOAD/CENTER.
    always_comb begin
        state_next      = state_reg;
        ch_next         = ch_reg;
        tap_next        = tap_reg;
        cnt_next        = cnt_reg;
        pass_next       = pass_reg;
        start_next      = 1'b0;
        run_len_next    = run_len_reg;
        run_start_next  = run_start_reg;
        best_len_next   = best_len_reg;
        best_start_next = best_start_reg;
        for (int i = 0; i < CHANNELS; i++) lane_next[i] = lane_reg[i];
        ld_next         = '0;
        fail_next       = fail_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        ch_inc          = ch_reg + 1'b1;
        rl              = run_len_reg;
        rs              = run_start_reg;
        bl              = best_len_reg;
        bs              = best_start_reg;
        centre          = '0;

        case (state_reg)
            IDLE, DONE: begin
                if (start_reg) begin
                    state_next   = LOAD;
                    ch_next      = '0;
                    tap_next     = '0;
                    lane_next[0] = '0;
                    ld_next[0]   = 1'b1;
                    busy_next    = 1'b1;
                end else if (cal_start) begin
                    start_next = 1'b1;
                    done_next  = 1'b0;
                    fail_next  = '0;
                end
            end
            LOAD: begin
                state_next = SETTLE;
                cnt_next   = '0;
            end
            SETTLE: begin
                if (cnt_reg == CNTW'(SETTLE_CYCLES - 1)) begin
                    state_next = SAMPLE;
                    cnt_next   = '0;
                    pass_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SAMPLE: begin
                pass_next = pass_reg & pattern_ok[ch_reg];
                if (cnt_reg == CNTW'(SAMPLE_CYCLES - 1)) state_next = EVAL;
                else cnt_next = cnt_reg + 1'b1;
            end
            EVAL: begin
                if (pass_reg) begin
                    if (rl == '0) rs = tap_reg;
                    rl = rl + 1'b1;
                end else begin
                    if (rl > bl) begin
                        bl = rl;
                        bs = rs;
                    end
                    rl = '0;
                end
                if (tap_reg == W'(TAPS - 1)) begin
                    if (rl > bl) begin
                        bl = rl;
                        bs = rs;
                    end
                    rl         = '0;
                    state_next = CENTER;
                    if (bl >= (W+1)'(MIN_WINDOW)) begin
                        centre            = {1'b0, bs} + ((bl - 1'b1) >> 1);
                        lane_next[ch_reg] = centre[W-1:0];
                    end else begin
                        lane_next[ch_reg] = W'(DEFAULT_TAP);
                        fail_next[ch_reg] = 1'b1;
                    end
                    ld_next[ch_reg] = 1'b1;
                end else begin
                    state_next        = LOAD;
                    tap_next          = tap_reg + 1'b1;
                    lane_next[ch_reg] = tap_reg + 1'b1;
                    ld_next[ch_reg]   = 1'b1;
                end
                run_len_next    = rl;
                run_start_next  = rs;
                best_len_next   = bl;
                best_start_next = bs;
            end
            CENTER: state_next = NEXT_CH;
            NEXT_CH: begin
                run_len_next    = '0;
                run_start_next  = '0;
                best_len_next   = '0;
                best_start_next = '0;
                if (ch_reg == CHW'(CHANNELS - 1)) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    state_next        = LOAD;
                    ch_next           = ch_inc;
                    tap_next          = '0;
                    lane_next[ch_inc] = '0;
                    ld_next[ch_inc]   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            assign dly_cntvalue[gi*W +: W] = lane_reg[gi];
        end
    endgenerate

    assign dly_ld   = ld_reg;
    assign cal_busy = busy_reg;
    assign cal_done = done_reg;
    assign cal_fail = fail_reg;

endmodule

// File: tb/tb_adc_idelay_calib.sv
// Bench for adc_idelay_calib: per-tap pass tables drive pattern_ok, a window-search model
// predicts lanes/fail bits, and a monitor scores every completed calibration.
module tb_adc_idelay_calib;

    logic        refclk = 1'b0;
    logic        rst_asyn_n = 1'b0;
    logic        cal_start = 1'b0;
    logic [1:0]  pattern_ok;
    logic [9:0]  dly_cntvalue;
    logic [1:0]  dly_ld;
    logic        cal_busy, cal_done;
    logic [1:0]  cal_fail;

    adc_idelay_calib #(
        .CHANNELS(2), .CNTVALUE_WIDTH(5), .DEFAULT_TAP(16),
        .SETTLE_CYCLES(4), .SAMPLE_CYCLES(8), .MIN_WINDOW(3)
    ) dut (
        .refclk(refclk), .rst_asyn_n(rst_asyn_n), .cal_start(cal_start),
        .pattern_ok(pattern_ok), .dly_cntvalue(dly_cntvalue), .dly_ld(dly_ld),
        .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [4:0] l0;
        logic [4:0] l1;
        logic [1:0] fail;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] tbl [2];
    int          glitch_ch = -1;
    int          glitch_tap = -1;
    int          since [2];
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  lane0, lane1;

    assign lane0 = dly_cntvalue[4:0];
    assign lane1 = dly_cntvalue[9:5];
    // A glitch knocks pattern_ok low for the third sample cycle of the chosen tap.
    assign pattern_ok[0] = tbl[0][lane0] && !(glitch_ch == 0 && int'(lane0) == glitch_tap && since[0] == 7);
    assign pattern_ok[1] = tbl[1][lane1] && !(glitch_ch == 1 && int'(lane1) == glitch_tap && since[1] == 7);

    always @(negedge refclk) begin
        for (int k = 0; k < 2; k++) since[k] = dly_ld[k] ? 0 : since[k] + 1;
    end

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Widest run of passing taps, lowest start on ties, floor centre.
    function automatic void model(input logic [31:0] p, output logic [4:0] lane, output logic fl);
        int bl = 0;
        int bs = 0;
        for (int s = 0; s < 32; s++) begin
            if (p[s] && (s == 0 || !p[s-1])) begin
                int n = 0;
                while (s + n < 32 && p[s+n]) n++;
                if (n > bl) begin
                    bl = n;
                    bs = s;
                end
            end
        end
        if (bl >= 3) begin
            lane = 5'(bs + (bl - 1) / 2);
            fl   = 1'b0;
        end else begin
            lane = 5'd16;
            fl   = 1'b1;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        int   negcnt = 0;
        int   start_neg = 0;
        int   ld_cnt = 0;
        int   onehot_bad = 0;
        bit   waiting = 0;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge refclk);
            negcnt++;
            if (!rst_asyn_n) begin
                waiting   = 0;
                prev_done = 1'b0;
                continue;
            end
            if (cal_start && !cal_busy) begin
                start_neg  = negcnt;
                waiting    = 1;
                ld_cnt     = 0;
                onehot_bad = 0;
            end
            if ($countones(dly_ld) > 1) onehot_bad++;
            ld_cnt += $countones(dly_ld);
            if (cal_done && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("lane0", lane0, e.l0);
                    check("lane1", lane1, e.l1);
                    check("cal_fail", cal_fail, e.fail);
                    check("done_latency", negcnt - start_neg, 901);
                    check("ld_pulses", ld_cnt, 66);
                    check("ld_onehot_violations", onehot_bad, 0);
                    $display("run done: lane0=%0d lane1=%0d fail=%b latency=%0d ld=%0d",
                             lane0, lane1, cal_fail, negcnt - start_neg, ld_cnt);
                end
                waiting = 0;
            end
            if (waiting && (negcnt - start_neg) > 1000) begin
                check("done_timeout", 1, 0);
                waiting = 0;
                if (sb.size() != 0) void'(sb.pop_front());
            end
            prev_done = cal_done;
        end
    endtask

    task automatic pulse_start();
        @(negedge refclk);
        #1 cal_start = 1'b1;
        @(negedge refclk);
        #1 cal_start = 1'b0;
    endtask

    task automatic run_cal(input logic [31:0] t0, input logic [31:0] t1,
                           input int gch, input int gtap, input bit pulse_mid);
        exp_t        e;
        logic [31:0] p0 = t0;
        logic [31:0] p1 = t1;
        int          n = 0;
        tbl[0] = t0;
        tbl[1] = t1;
        glitch_ch  = gch;
        glitch_tap = gtap;
        if (gch == 0 && gtap >= 0) p0[gtap] = 1'b0;
        if (gch == 1 && gtap >= 0) p1[gtap] = 1'b0;
        model(p0, e.l0, e.fail[0]);
        model(p1, e.l1, e.fail[1]);
        sb.push_back(e);
        pulse_start();
        if (pulse_mid) begin
            repeat (200) @(negedge refclk);
            pulse_start();
        end
        while (!cal_done && n < 1200) begin
            @(negedge refclk);
            n++;
        end
        repeat (3) @(negedge refclk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_lane0"}, lane0, 16);
        check({tag, "_lane1"}, lane1, 16);
        check({tag, "_ld"}, dly_ld, 0);
        check({tag, "_busy"}, cal_busy, 0);
        check({tag, "_done"}, cal_done, 0);
        check({tag, "_fail"}, cal_fail, 0);
        $display("reset check %s: lane0=%0d lane1=%0d ld=%b busy=%b done=%b fail=%b",
                 tag, lane0, lane1, dly_ld, cal_busy, cal_done, cal_fail);
    endtask

    task automatic driver();
        logic [31:0] r0, r1;
        tbl[0] = '0;
        tbl[1] = '0;
        #12;
        check_reset_values("por");
        @(negedge refclk);
        #1 rst_asyn_n = 1'b1;
        repeat (2) @(negedge refclk);

        run_cal(win(6, 17), win(25, 31), -1, -1, 0);
        run_cal(win(2, 5) | win(20, 27), win(25, 31), -1, -1, 0);
        run_cal(win(0, 3) | win(10, 13), win(8, 12), -1, -1, 0);
        run_cal(win(6, 17), win(25, 31), 0, 10, 0);
        run_cal(win(6, 17), 32'h0, -1, -1, 0);
        run_cal(win(6, 17), win(4, 5), -1, -1, 0);
        run_cal(win(6, 17), win(25, 31), -1, -1, 1);
        run_cal(win(6, 17), win(25, 31), -1, -1, 0);
        run_cal(32'hFFFF_FFFF, win(29, 31), -1, -1, 0);

        // Abort a sweep part-way through; outputs must drop to reset values at once.
        pulse_start();
        repeat (300) @(negedge refclk);
        #3 rst_asyn_n = 1'b0;
        #1 check_reset_values("mid_sweep");
        @(negedge refclk);
        #1 rst_asyn_n = 1'b1;
        repeat (2) @(negedge refclk);

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                r0 = $urandom;
                r1 = $urandom | $urandom;
            end else begin
                int lo = $urandom_range(0, 28);
                int hi = $urandom_range(lo, 31);
                int lo2 = $urandom_range(0, 31);
                r0 = win(lo, hi) | win(lo2, lo2 + int'($urandom_range(0, 3)) > 31 ? 31 : lo2 + int'($urandom_range(0, 3)));
                r1 = win($urandom_range(0, 15), $urandom_range(16, 31));
            end
            run_cal(r0, r1, (i % 3 == 0) ? 1 : -1, int'($urandom_range(0, 31)), 0);
        end
    endtask

    initial begin
        fork
            monitor();
            driver();
        join_any
        if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
